bus_master_if: RTL and testbench
================================

BUS_MASTER_IF -- requirements
Module: bus_master_if

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, max ACCESS cycles waited for bus_rdy_ before abort (range 2..255).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_en  in  1  CPU requests a bus access this cycle.
REQ-005 rw  in  1  access type; READ=1, WRITE=0.
REQ-006 addr  in  30  CPU word address.
REQ-007 wr_data  in  32  CPU write data.
REQ-008 stall  in  1  CPU pipeline stalled; hold the returned read data.
REQ-009 flush  in  1  CPU flush; cancel or discard the current request.
REQ-010 rd_data  out  32  read data returned to the CPU.
REQ-011 busy  out  1  CPU must stall; access not complete.
REQ-012 err  out  1  one-cycle pulse on bus timeout.
REQ-013 bus_req_  out  1  bus request to the arbiter; active-low.
REQ-014 bus_grnt_  in  1  bus grant from the arbiter; active-low.
REQ-015 bus_as_  out  1  address strobe; active-low.
REQ-016 bus_addr  out  30  bus address.
REQ-017 bus_rw  out  1  bus access type; READ=1, WRITE=0.
REQ-018 bus_wr_data  out  32  bus write data.
REQ-019 bus_rd_data  in  32  slave read data; valid while bus_rdy_ is low.
REQ-020 bus_rdy_  in  1  slave ready; active-low.

Function
REQ-021 FSM states SHALL be IDLE, REQ, ACCESS, STALL; all bus_* outputs registered.
REQ-022 IDLE: on req_en=1 and flush=0 -> REQ, bus_req_=0 next cycle, addr/rw/wr_data latched; busy=req_en combinationally.
REQ-023 REQ: bus_grnt_=0 and flush=0 -> ACCESS, with bus_as_=0 for exactly one cycle carrying the latched addr/rw/wr_data.
REQ-024 REQ with flush=1 -> IDLE; bus_req_=1 next cycle; no strobe issued; flush has priority over grant.
REQ-025 ACCESS: bus_addr/bus_rw/bus_wr_data held until completion; timeout counter increments each cycle.
REQ-026 ACCESS, bus_rdy_=0 -> busy=0 and rd_data=bus_rd_data in the same cycle; read data captured into a hold register; bus_req_=1 next cycle.
REQ-027 On completion -> STALL if stall=1, else IDLE.
REQ-028 STALL: busy=0, rd_data=hold register; exit to IDLE when stall=0.
REQ-029 flush during ACCESS SHALL NOT abort the bus cycle; completion proceeds as normal, result discarded, rd_data=0, next state IDLE.
REQ-030 Timeout: counter reaches TIMEOUT_CYCLES with bus_rdy_ still 1 -> err=1 for one cycle, busy=0, rd_data=0, bus released, next state IDLE.
REQ-031 bus_rdy_=0 in the same cycle as the timeout SHALL count as completion; err stays 0.
REQ-032 Minimum latency, with immediate grant: req_en at cycle 0, REQ at 1, strobe at 2, completion at 3.
REQ-033 Bus outputs when not strobing/owning: bus_as_=1, bus_addr=0, bus_wr_data=0, bus_rw=READ.
REQ-034 bus_rdy_ sampled outside ACCESS SHALL be ignored.

Reset
REQ-035 reset=1 at a clock edge -> IDLE, bus_req_=1, bus_as_=1, bus_addr=0, bus_wr_data=0, bus_rw=READ, err=0, hold register=0, counter=0.
REQ-036 Reset mid-access SHALL abandon the cycle silently, with no err; a later bus_rdy_ is ignored.

Structure
REQ-037 Shared package bus_pkg: ENABLE_/DISABLE_ (0/1), READ/WRITE, state encoding, WORD_ADDR_W=30, DATA_W=32.
REQ-038 One sub-module, bus_timeout_cnt: clear, enable, and terminal-count flag.

Verification
REQ-039 Read, grant immediate, slave rdy_ one cycle after strobe, addr=0x10, data=0xDEADBEEF -> busy low and rd_data=0xDEADBEEF at cycle 3, bus_req_ high at cycle 4.
REQ-040 Write, addr=0x20, wr_data=0x12345678, grant delayed 4 cycles -> single strobe at cycle 6 with bus_rw=0 and data stable until rdy_.
REQ-041 Read completes with stall=1 for 3 cycles, bus_rd_data changed afterwards -> rd_data holds the captured value, then IDLE.
REQ-042 TIMEOUT_CYCLES=8, slave never responds -> err pulse after 8 ACCESS cycles, rd_data=0, bus_req_ high next cycle.
REQ-043 flush in REQ -> no bus_as_ ever; flush in ACCESS -> rdy_ accepted, rd_data=0, no err.
REQ-044 reset asserted in ACCESS, then late bus_rdy_=0 -> outputs at reset values, no busy/err/rd_data change.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bus_pkg                                                        |
// | Purpose  : Shared constants, bus polarities and FSM state encoding for   |
// |            the CPU-side bus master interface.                            |
// | Contents : ENABLE_/DISABLE_ (active-low strobe levels), READ/WRITE,       |
// |            WORD_ADDR_W, DATA_W, state_t.                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package bus_pkg;

    // Active-low control levels used on bus_req_, bus_as_, bus_grnt_, bus_rdy_
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Access type encoding
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam int WORD_ADDR_W = 30;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        STALL  = 2'd3
    } state_t;

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_master_if_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bus_if                                                         |
// | Purpose  : Arbitrated system bus signal bundle.                          |
// | Ports    : master modport drives bus_req_, bus_as_, bus_addr, bus_rw,    |
// |            bus_wr_data and samples bus_grnt_, bus_rd_data, bus_rdy_;     |
// |            slave modport is the mirror image.                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface bus_if;
    import bus_pkg::*;

    logic                   bus_req_;
    logic                   bus_grnt_;
    logic                   bus_as_;
    logic [WORD_ADDR_W-1:0] bus_addr;
    logic                   bus_rw;
    logic [DATA_W-1:0]      bus_wr_data;
    logic [DATA_W-1:0]      bus_rd_data;
    logic                   bus_rdy_;

    modport master (
        output bus_req_, bus_as_, bus_addr, bus_rw, bus_wr_data,
        input  bus_grnt_, bus_rd_data, bus_rdy_
    );

    modport slave (
        input  bus_req_, bus_as_, bus_addr, bus_rw, bus_wr_data,
        output bus_grnt_, bus_rd_data, bus_rdy_
    );

endinterface : bus_if
`default_nettype wire

// File: rtl/bus_timeout_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bus_timeout_cnt                                                |
// | Purpose  : Counts bus ACCESS cycles and flags the last allowed cycle.    |
// | Ports    : clk, reset (sync, active-high), clear (priority over enable),  |
// |            enable (count this cycle), tc (current cycle is the           |
// |            MAX_COUNT-th enabled cycle since clear).                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bus_timeout_cnt #(
    parameter int MAX_COUNT = 255
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic enable,
    output logic      tc
);

    localparam int CNT_W = 8;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Count starts at 0 in the first counted cycle, so the MAX_COUNT-th
    // cycle is the one where the count equals MAX_COUNT-1.
    assign tc = (r_count == CNT_W'(MAX_COUNT - 1));

endmodule : bus_timeout_cnt
`default_nettype wire

// File: rtl/bus_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bus_master_if                                                  |
// | Purpose  : Bridges single CPU word accesses onto an arbitrated,          |
// |            active-low handshake bus with a slave-response timeout.       |
// | Ports    : clk, reset (sync, active-high); CPU side req_en, rw, addr,    |
// |            wr_data, stall, flush in / rd_data, busy, err out;            |
// |            bus (bus_if.master) towards arbiter and slave.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bus_master_if
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   req_en,
    input  wire logic                   rw,
    input  wire logic [WORD_ADDR_W-1:0] addr,
    input  wire logic [DATA_W-1:0]      wr_data,
    input  wire logic                   stall,
    input  wire logic                   flush,
    output logic      [DATA_W-1:0]      rd_data,
    output logic                        busy,
    output logic                        err,
    bus_if.master                       bus
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [WORD_ADDR_W-1:0] r_addr;
    logic                   r_rw;
    logic [DATA_W-1:0]      r_wr_data;
    logic [DATA_W-1:0]      r_hold;
    logic                   r_flushed;
    logic                   w_complete;
    logic                   w_discard;
    logic                   w_tc;

    bus_timeout_cnt #(
        .MAX_COUNT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (r_state != ACCESS),
        .enable (r_state == ACCESS),
        .tc     (w_tc)
    );

    // A flush seen at any point of the access discards its result; the bus
    // cycle itself always runs to completion.
    assign w_discard = r_flushed | flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        rd_data      = '0;
        err          = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                busy = req_en;
                if (req_en && !flush) begin
                    w_next_state = REQ;
                end
            end
            REQ: begin
                busy = 1'b1;
                // Flush wins over a simultaneous grant: no strobe is issued.
                if (flush) begin
                    w_next_state = IDLE;
                end else if (bus.bus_grnt_ == ENABLE_) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                // Ready in the timeout cycle still counts as completion.
                if (bus.bus_rdy_ == ENABLE_) begin
                    w_complete = 1'b1;
                    if (w_discard) begin
                        w_next_state = IDLE;
                    end else begin
                        rd_data      = bus.bus_rd_data;
                        w_next_state = stall ? STALL : IDLE;
                    end
                end else if (w_tc) begin
                    err          = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            STALL: begin
                rd_data = r_hold;
                if (!stall) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // CPU request capture and read-data hold register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_rw      <= READ;
            r_wr_data <= '0;
            r_hold    <= '0;
            r_flushed <= 1'b0;
        end else begin
            if (r_state == IDLE && req_en && !flush) begin
                r_addr    <= addr;
                r_rw      <= rw;
                r_wr_data <= wr_data;
            end
            if (w_complete && !w_discard) begin
                r_hold <= bus.bus_rd_data;
            end
            r_flushed <= (r_state == ACCESS && w_next_state == ACCESS) ?
                         (r_flushed | flush) : 1'b0;
        end
    end

    // Registered bus side: request held while in REQ/ACCESS, strobe only on
    // the REQ->ACCESS transition, address/data parked at idle values
    // whenever the bus is not owned.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.bus_req_    <= DISABLE_;
            bus.bus_as_     <= DISABLE_;
            bus.bus_addr    <= '0;
            bus.bus_rw      <= READ;
            bus.bus_wr_data <= '0;
        end else begin
            bus.bus_req_ <= (w_next_state == REQ || w_next_state == ACCESS) ?
                            ENABLE_ : DISABLE_;
            bus.bus_as_  <= (r_state == REQ && w_next_state == ACCESS) ?
                            ENABLE_ : DISABLE_;
            if (w_next_state == ACCESS) begin
                bus.bus_addr    <= r_addr;
                bus.bus_rw      <= r_rw;
                bus.bus_wr_data <= r_wr_data;
            end else begin
                bus.bus_addr    <= '0;
                bus.bus_rw      <= READ;
                bus.bus_wr_data <= '0;
            end
        end
    end

endmodule : bus_master_if
`default_nettype wire

// File: tb/tb_bus_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bus_master_if                                               |
// | Purpose  : Directed self-checking bench for bus_master_if with           |
// |            TIMEOUT_CYCLES=8; arbiter and slave are driven directly.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bus_master_if;
    import bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_en;
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wr_data;
    logic        stall;
    logic        flush;
    logic [31:0] rd_data;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    bus_if bus ();

    bus_master_if #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req_en  (req_en),
        .rw      (rw),
        .addr    (addr),
        .wr_data (wr_data),
        .stall   (stall),
        .flush   (flush),
        .rd_data (rd_data),
        .busy    (busy),
        .err     (err),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Move to the next cycle; registered outputs settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs.
    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; req_en = 1'b0; rw = 1'b0; addr = '0; wr_data = '0;
        stall = 1'b0; flush = 1'b0;
        bus.bus_grnt_ = 1'b1; bus.bus_rdy_ = 1'b1; bus.bus_rd_data = '0;

        // ---------------- reset state ----------------
        tick(); tick(); settle();
        chk("rst_req_",  32'(bus.bus_req_), 32'd1);
        chk("rst_as_",   32'(bus.bus_as_), 32'd1);
        chk("rst_addr",  32'(bus.bus_addr), 32'd0);
        chk("rst_wdata", bus.bus_wr_data, 32'd0);
        chk("rst_rw",    32'(bus.bus_rw), 32'd1);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        reset = 1'b0;

        // ---------------- read, immediate grant, rdy_ one cycle after strobe
        tick(); req_en = 1'b1; rw = 1'b1; addr = 30'h10; bus.bus_grnt_ = 1'b0; settle();
        chk("rd_c0_busy", 32'(busy), 32'd1);
        tick(); req_en = 1'b0; addr = 30'h3FF; settle();
        chk("rd_c1_req_", 32'(bus.bus_req_), 32'd0);
        chk("rd_c1_as_",  32'(bus.bus_as_), 32'd1);
        chk("rd_c1_busy", 32'(busy), 32'd1);
        tick(); settle();
        chk("rd_c2_as_",  32'(bus.bus_as_), 32'd0);
        chk("rd_c2_addr", 32'(bus.bus_addr), 32'h10);
        chk("rd_c2_rw",   32'(bus.bus_rw), 32'd1);
        chk("rd_c2_busy", 32'(busy), 32'd1);
        tick(); bus.bus_rdy_ = 1'b0; bus.bus_rd_data = 32'hDEADBEEF; settle();
        chk("rd_c3_busy", 32'(busy), 32'd0);
        chk("rd_c3_data", rd_data, 32'hDEADBEEF);
        chk("rd_c3_as_",  32'(bus.bus_as_), 32'd1);
        chk("rd_c3_addr", 32'(bus.bus_addr), 32'h10);
        tick(); bus.bus_rdy_ = 1'b1; bus.bus_rd_data = '0; bus.bus_grnt_ = 1'b1; settle();
        chk("rd_c4_req_", 32'(bus.bus_req_), 32'd1);
        chk("rd_c4_addr", 32'(bus.bus_addr), 32'd0);
        chk("rd_c4_data", rd_data, 32'd0);

        // ---------------- write, grant delayed 4 cycles
        tick(); req_en = 1'b1; rw = 1'b0; addr = 30'h20; wr_data = 32'h12345678; settle();
        chk("wr_c0_busy", 32'(busy), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            tick(); req_en = 1'b0; addr = 30'h3FF; wr_data = 32'hFFFFFFFF; settle();
            chk("wr_req_wait_as_",  32'(bus.bus_as_), 32'd1);
            chk("wr_req_wait_req_", 32'(bus.bus_req_), 32'd0);
        end
        tick(); bus.bus_grnt_ = 1'b0; settle();
        chk("wr_c5_as_", 32'(bus.bus_as_), 32'd1);
        tick(); bus.bus_grnt_ = 1'b1; settle();
        chk("wr_c6_as_",    32'(bus.bus_as_), 32'd0);
        chk("wr_c6_rw",     32'(bus.bus_rw), 32'd0);
        chk("wr_c6_addr",   32'(bus.bus_addr), 32'h20);
        chk("wr_c6_wdata",  bus.bus_wr_data, 32'h12345678);
        tick(); settle();
        chk("wr_c7_as_",    32'(bus.bus_as_), 32'd1);
        chk("wr_c7_wdata",  bus.bus_wr_data, 32'h12345678);
        chk("wr_c7_busy",   32'(busy), 32'd1);
        tick(); bus.bus_rdy_ = 1'b0; settle();
        chk("wr_c8_busy",   32'(busy), 32'd0);
        chk("wr_c8_wdata",  bus.bus_wr_data, 32'h12345678);
        tick(); bus.bus_rdy_ = 1'b1; wr_data = '0; settle();
        chk("wr_c9_wdata",  bus.bus_wr_data, 32'd0);
        chk("wr_c9_req_",   32'(bus.bus_req_), 32'd1);
        chk("wr_c9_rw",     32'(bus.bus_rw), 32'd1);

        // ---------------- read completing under stall
        tick(); req_en = 1'b1; rw = 1'b1; addr = 30'h30; bus.bus_grnt_ = 1'b0; settle();
        tick(); req_en = 1'b0; settle();
        tick(); settle();
        tick(); bus.bus_rdy_ = 1'b0; bus.bus_rd_data = 32'hCAFEF00D; stall = 1'b1; settle();
        chk("st_c3_data", rd_data, 32'hCAFEF00D);
        tick(); bus.bus_rdy_ = 1'b1; bus.bus_rd_data = 32'h55555555; bus.bus_grnt_ = 1'b1; settle();
        chk("st_c4_data", rd_data, 32'hCAFEF00D);
        chk("st_c4_busy", 32'(busy), 32'd0);
        chk("st_c4_req_", 32'(bus.bus_req_), 32'd1);
        tick(); settle();
        chk("st_c5_data", rd_data, 32'hCAFEF00D);
        tick(); stall = 1'b0; settle();
        chk("st_c6_data", rd_data, 32'hCAFEF00D);
        tick(); settle();
        chk("st_c7_idle_data", rd_data, 32'd0);

        // ---------------- timeout: slave never responds
        tick(); req_en = 1'b1; addr = 30'h40; bus.bus_grnt_ = 1'b0;
        bus.bus_rd_data = 32'hA5A5A5A5; settle();
        tick(); req_en = 1'b0; settle();
        for (int c = 2; c <= 8; c++) begin
            tick(); settle();
            chk("to_wait_err",  32'(err), 32'd0);
            chk("to_wait_busy", 32'(busy), 32'd1);
        end
        tick(); settle();
        chk("to_c9_err",  32'(err), 32'd1);
        chk("to_c9_busy", 32'(busy), 32'd0);
        chk("to_c9_data", rd_data, 32'd0);
        tick(); bus.bus_grnt_ = 1'b1; settle();
        chk("to_c10_err",  32'(err), 32'd0);
        chk("to_c10_req_", 32'(bus.bus_req_), 32'd1);
        chk("to_c10_addr", 32'(bus.bus_addr), 32'd0);

        // ---------------- ready arriving in the timeout cycle completes
        tick(); req_en = 1'b1; addr = 30'h44; bus.bus_grnt_ = 1'b0; settle();
        tick(); req_en = 1'b0; settle();
        for (int c = 2; c <= 8; c++) begin
            tick(); settle();
        end
        tick(); bus.bus_rdy_ = 1'b0; bus.bus_rd_data = 32'h0BADF00D; settle();
        chk("tr_c9_err",  32'(err), 32'd0);
        chk("tr_c9_data", rd_data, 32'h0BADF00D);
        chk("tr_c9_busy", 32'(busy), 32'd0);
        tick(); bus.bus_rdy_ = 1'b1; bus.bus_grnt_ = 1'b1; settle();
        chk("tr_c10_req_", 32'(bus.bus_req_), 32'd1);

        // ---------------- flush in REQ, together with grant
        tick(); req_en = 1'b1; addr = 30'h48; settle();
        tick(); req_en = 1'b0; flush = 1'b1; bus.bus_grnt_ = 1'b0; settle();
        chk("fr_c1_busy", 32'(busy), 32'd1);
        tick(); flush = 1'b0; settle();
        chk("fr_c2_as_",  32'(bus.bus_as_), 32'd1);
        chk("fr_c2_req_", 32'(bus.bus_req_), 32'd1);
        chk("fr_c2_busy", 32'(busy), 32'd0);
        tick(); settle();
        chk("fr_c3_as_",  32'(bus.bus_as_), 32'd1);

        // ---------------- flush in ACCESS: cycle completes, data discarded
        tick(); req_en = 1'b1; addr = 30'h50; settle();
        tick(); req_en = 1'b0; settle();
        tick(); flush = 1'b1; settle();
        chk("fa_c2_as_", 32'(bus.bus_as_), 32'd0);
        tick(); flush = 1'b0; stall = 1'b1; bus.bus_rdy_ = 1'b0;
        bus.bus_rd_data = 32'h77777777; settle();
        chk("fa_c3_data", rd_data, 32'd0);
        chk("fa_c3_busy", 32'(busy), 32'd0);
        chk("fa_c3_err",  32'(err), 32'd0);
        tick(); bus.bus_rdy_ = 1'b1; settle();
        chk("fa_c4_data_idle", rd_data, 32'd0);
        chk("fa_c4_req_",      32'(bus.bus_req_), 32'd1);
        stall = 1'b0;

        // ---------------- reset mid-access, then a late ready
        tick(); req_en = 1'b1; addr = 30'h60; settle();
        tick(); req_en = 1'b0; settle();
        tick(); settle();
        chk("ra_c2_as_", 32'(bus.bus_as_), 32'd0);
        tick(); reset = 1'b1; settle();
        chk("ra_c3_busy", 32'(busy), 32'd1);
        tick(); reset = 1'b0; bus.bus_rdy_ = 1'b0; bus.bus_rd_data = 32'h99999999; settle();
        chk("ra_c4_busy", 32'(busy), 32'd0);
        chk("ra_c4_err",  32'(err), 32'd0);
        chk("ra_c4_data", rd_data, 32'd0);
        chk("ra_c4_req_", 32'(bus.bus_req_), 32'd1);
        chk("ra_c4_as_",  32'(bus.bus_as_), 32'd1);
        chk("ra_c4_addr", 32'(bus.bus_addr), 32'd0);
        tick(); bus.bus_rdy_ = 1'b1; settle();
        chk("ra_c5_req_", 32'(bus.bus_req_), 32'd1);
        chk("ra_c5_data", rd_data, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bus_master_if
`default_nettype wire
